// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
//
// Signal bundle around the ID/EX pipeline register.
//
// The decode stage presents id_* every cycle. There is no valid/ready
// handshake. id_valid qualifies the id_* payload. The stage takes the payload
// on any rising edge with stall=0 and flush=0. stall and flush are plain
// scalar ports on the stage, not part of this bundle.
//
// The exm_* and mwb_* groups carry the writeback information of the two
// downstream stages. The stage samples them combinationally for forwarding.
//
// Modports:
//   slave  - the stage itself. Receives id_*, exm_* and mwb_*. Drives alu_*,
//            ex_* and fwd_*.
//   master - the environment, meaning decode, later stages or a bench. It is
//            the mirror image of slave.
//
// Parameters:
//   DATA_W - operand/result width
//   REG_AW - register specifier width
//   OP_W   - ALU operation code width
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
);
    // decode side
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [4:0]        id_shamt;
    logic [OP_W-1:0]   id_operation;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;

    // writeback info from EX/MEM and MEM/WB
    logic              exm_reg_write;
    logic [REG_AW-1:0] exm_rd;
    logic [DATA_W-1:0] exm_result;
    logic              mwb_reg_write;
    logic [REG_AW-1:0] mwb_rd;
    logic [DATA_W-1:0] mwb_result;

    // ALU / execute side
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [4:0]        alu_shamt;
    logic [OP_W-1:0]   alu_operation;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_illegal_op;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_use_imm, id_shamt,
               id_operation, id_rs, id_rt, id_rd, id_reg_write,
               exm_reg_write, exm_rd, exm_result,
               mwb_reg_write, mwb_rd, mwb_result,
        output alu_src1, alu_src2, alu_shamt, alu_operation,
               ex_valid, ex_rd, ex_reg_write, ex_illegal_op, fwd_a, fwd_b
    );

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_use_imm, id_shamt,
               id_operation, id_rs, id_rt, id_rd, id_reg_write,
               exm_reg_write, exm_rd, exm_result,
               mwb_reg_write, mwb_rd, mwb_result,
        input  alu_src1, alu_src2, alu_shamt, alu_operation,
               ex_valid, ex_rd, ex_reg_write, ex_illegal_op, fwd_a, fwd_b
    );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register plus operand forwarding in front of the ALU.
//
// Every cycle the stage captures the decoded operands and control. It then
// resolves RAW hazards against the EX/MEM and MEM/WB writeback info, and
// drives the ALU's src1, src2, shamt and operation inputs.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset. Clears every stage register.
//   stall  - hold every stage register. Forwarding stays live.
//   flush  - load a bubble on the next edge. Wins over stall.
//   bus    - id_ex_stage_if.slave. Carries the decode inputs, the writeback
//            inputs and the ALU/execute outputs, including the fwd_a/fwd_b
//            debug selects (0 regfile, 1 EX/MEM, 2 MEM/WB).
//
// Configuration:
//   ID_EX_FORWARDING_EN
//     Defined: forwarding is enabled.
//     Undefined (default): operands come only from the registered
//     register-file data or the immediate, and fwd_a/fwd_b read 0. Upstream
//     logic must then stall on hazards.
//
// Legal ALU ops: 0 nop, 27 add, 28 sub, 29 and, 30 or, 31 srl, 32 sll.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall,
    input  logic           flush,
    id_ex_stage_if.slave   bus
);

    localparam logic [OP_W-1:0] OP_NOP   = '0;
    localparam logic [OP_W-1:0] OP_FIRST = OP_W'(27);  // add
    localparam logic [OP_W-1:0] OP_LAST  = OP_W'(32);  // sll

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EXM = 2'd1;
    localparam logic [1:0] SEL_MWB = 2'd2;

    // All ID/EX state lives in one struct. A bubble is simply all-zero.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [4:0]        shamt;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              illegal;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    logic   op_legal;

    // -------------------------------------------------------------------------
    // Opcode legality
    // -------------------------------------------------------------------------
    always_comb begin
        op_legal = (bus.id_operation == OP_NOP) ||
                   ((bus.id_operation >= OP_FIRST) && (bus.id_operation <= OP_LAST));
    end

    // -------------------------------------------------------------------------
    // Next-state selection.
    // Priority: flush, then stall, then capture. An id_valid=0 capture loads
    // the same all-zero bubble as a flush.
    // -------------------------------------------------------------------------
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            if (!bus.id_valid) begin
                stage_d = '0;
            end else begin
                stage_d.valid   = 1'b1;
                stage_d.rs_data = bus.id_rs_data;
                stage_d.rt_data = bus.id_rt_data;
                stage_d.imm     = bus.id_imm;
                stage_d.use_imm = bus.id_use_imm;
                stage_d.shamt   = bus.id_shamt;
                stage_d.rs      = bus.id_rs;
                stage_d.rt      = bus.id_rt;
                stage_d.rd      = bus.id_rd;
                // An illegal op stays a valid instruction so the trap can be
                // seen downstream. It is neutered here: it becomes a nop and
                // has no writeback.
                stage_d.op        = op_legal ? bus.id_operation : OP_NOP;
                stage_d.reg_write = op_legal ? bus.id_reg_write : 1'b0;
                stage_d.illegal   = !op_legal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand forwarding.
    // The selects are computed from the registered rs/rt and the live
    // writeback inputs, so they track exm_*/mwb_* even while stalled.
    // EX/MEM is the younger result and wins over MEM/WB. r0 is hardwired to
    // zero and is never forwarded.
    // -------------------------------------------------------------------------
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

`ifdef ID_EX_FORWARDING_EN
    logic exm_hit_a;
    logic exm_hit_b;
    logic mwb_hit_a;
    logic mwb_hit_b;

    always_comb begin
        exm_hit_a = bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == stage_q.rs);
        exm_hit_b = bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == stage_q.rt);
        mwb_hit_a = bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == stage_q.rs);
        mwb_hit_b = bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == stage_q.rt);
    end

    always_comb begin
        sel_a  = SEL_RF;
        opnd_a = stage_q.rs_data;
        if (exm_hit_a) begin
            sel_a  = SEL_EXM;
            opnd_a = bus.exm_result;
        end else if (mwb_hit_a) begin
            sel_a  = SEL_MWB;
            opnd_a = bus.mwb_result;
        end
    end

    always_comb begin
        sel_b  = SEL_RF;
        opnd_b = stage_q.rt_data;
        if (exm_hit_b) begin
            sel_b  = SEL_EXM;
            opnd_b = bus.exm_result;
        end else if (mwb_hit_b) begin
            sel_b  = SEL_MWB;
            opnd_b = bus.mwb_result;
        end
    end
`else
    // No bypass network. The writeback inputs and the registered specifiers
    // are deliberately left without a consumer.
    logic unused_fwd_inputs;

    always_comb begin
        sel_a  = SEL_RF;
        sel_b  = SEL_RF;
        opnd_a = stage_q.rs_data;
        opnd_b = stage_q.rt_data;
    end

    assign unused_fwd_inputs = ^{bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                                 bus.mwb_reg_write, bus.mwb_rd, bus.mwb_result,
                                 stage_q.rs, stage_q.rt, SEL_EXM, SEL_MWB};
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // fwd_b keeps reporting the B-path select even when the immediate
    // overrides src2. This keeps the hazard visible for debug.
    assign bus.alu_src1      = opnd_a;
    assign bus.alu_src2      = stage_q.use_imm ? stage_q.imm : opnd_b;
    assign bus.alu_shamt     = stage_q.shamt;
    assign bus.alu_operation = stage_q.op;
    assign bus.ex_valid      = stage_q.valid;
    assign bus.ex_rd         = stage_q.rd;
    assign bus.ex_reg_write  = stage_q.reg_write && stage_q.valid && (stage_q.rd != '0);
    assign bus.ex_illegal_op = stage_q.illegal;
    assign bus.fwd_a         = sel_a;
    assign bus.fwd_b         = sel_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. Each scenario task drives its vectors and
// compares the outputs against hand-computed values. Values that depend on
// ID_EX_FORWARDING_EN follow the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 6;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    int passed = 0;
    int total  = 0;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0;
        bus.id_valid = 0; bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
        bus.id_use_imm = 0; bus.id_shamt = '0; bus.id_operation = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_reg_write = 0;
        bus.exm_reg_write = 0; bus.exm_rd = '0; bus.exm_result = '0;
        bus.mwb_reg_write = 0; bus.mwb_rd = '0; bus.mwb_result = '0;
    endtask

    task automatic drive_id(input logic [DATA_W-1:0] rs_d, input logic [DATA_W-1:0] rt_d,
                            input logic [OP_W-1:0] op, input logic [REG_AW-1:0] rs,
                            input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                            input logic wr);
        bus.id_valid = 1; bus.id_rs_data = rs_d; bus.id_rt_data = rt_d;
        bus.id_operation = op; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_reg_write = wr;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        // load a real instruction with live writeback traffic, then reset mid-cycle
        drive_id(32'd5, 32'd6, 6'd28, 5'd3, 5'd3, 5'd2, 1'b1);
        bus.exm_reg_write = 1; bus.exm_rd = 5'd3; bus.exm_result = 32'd44;
        tick();
        #2 rst_n = 0;
        #1;
        total++; if (bus.alu_src1 !== '0) $display("FAIL rst_src1 got %0d exp 0", bus.alu_src1); else passed++;
        total++; if (bus.alu_src2 !== '0) $display("FAIL rst_src2 got %0d exp 0", bus.alu_src2); else passed++;
        total++; if (bus.alu_operation !== '0) $display("FAIL rst_op got %0d exp 0", bus.alu_operation); else passed++;
        total++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_illegal_op, bus.ex_rd, bus.alu_shamt} !== '0)
            $display("FAIL rst_ctrl got v%0b w%0b i%0b rd%0d sh%0d exp all 0", bus.ex_valid,
                     bus.ex_reg_write, bus.ex_illegal_op, bus.ex_rd, bus.alu_shamt); else passed++;
        total++; if ({bus.fwd_a, bus.fwd_b} !== 4'd0) $display("FAIL rst_fwd got %0d/%0d exp 0/0", bus.fwd_a, bus.fwd_b); else passed++;
        // held in reset across an edge: the instruction is discarded
        clear_inputs();
        drive_id(32'd1, 32'd3, 6'd27, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        total++; if (bus.ex_valid !== 1'b0) $display("FAIL rst_hold_valid got %0b exp 0", bus.ex_valid); else passed++;
        rst_n = 1;
        tick();
        total++; if (bus.alu_src1 !== 32'd1) $display("FAIL cap_src1 got %0d exp 1", bus.alu_src1); else passed++;
        total++; if (bus.alu_src2 !== 32'd3) $display("FAIL cap_src2 got %0d exp 3", bus.alu_src2); else passed++;
        total++; if (bus.alu_operation !== 6'd27) $display("FAIL cap_op got %0d exp 27", bus.alu_operation); else passed++;
        total++; if (bus.ex_reg_write !== 1'b1) $display("FAIL cap_wr got %0b exp 1", bus.ex_reg_write); else passed++;
        total++; if (bus.ex_rd !== 5'd4) $display("FAIL cap_rd got %0d exp 4", bus.ex_rd); else passed++;
        total++; if (bus.ex_valid !== 1'b1) $display("FAIL cap_valid got %0b exp 1", bus.ex_valid); else passed++;
    endtask

    task automatic test_forward_priority();
        logic [DATA_W-1:0] e1, e2;
        logic [1:0]        ef;
        clear_inputs();
        drive_id(32'd11, 32'd22, 6'd27, 5'd5, 5'd5, 5'd6, 1'b1);
        bus.exm_reg_write = 1; bus.exm_rd = 5'd5; bus.exm_result = 32'd87;
        bus.mwb_reg_write = 1; bus.mwb_rd = 5'd5; bus.mwb_result = 32'd99;
        tick();
        e1 = FWD ? 32'd87 : 32'd11; e2 = FWD ? 32'd87 : 32'd22; ef = FWD ? 2'd1 : 2'd0;
        total++; if (bus.alu_src1 !== e1) $display("FAIL fwd_exm_src1 got %0d exp %0d", bus.alu_src1, e1); else passed++;
        total++; if (bus.alu_src2 !== e2) $display("FAIL fwd_exm_src2 got %0d exp %0d", bus.alu_src2, e2); else passed++;
        total++; if (bus.fwd_a !== ef || bus.fwd_b !== ef)
            $display("FAIL fwd_exm_sel got %0d/%0d exp %0d/%0d", bus.fwd_a, bus.fwd_b, ef, ef); else passed++;
        // drop EX/MEM: MEM/WB takes over without a clock edge
        bus.exm_reg_write = 0;
        #1;
        e1 = FWD ? 32'd99 : 32'd11; e2 = FWD ? 32'd99 : 32'd22; ef = FWD ? 2'd2 : 2'd0;
        total++; if (bus.alu_src1 !== e1) $display("FAIL fwd_mwb_src1 got %0d exp %0d", bus.alu_src1, e1); else passed++;
        total++; if (bus.alu_src2 !== e2) $display("FAIL fwd_mwb_src2 got %0d exp %0d", bus.alu_src2, e2); else passed++;
        total++; if (bus.fwd_a !== ef || bus.fwd_b !== ef)
            $display("FAIL fwd_mwb_sel got %0d/%0d exp %0d/%0d", bus.fwd_a, bus.fwd_b, ef, ef); else passed++;
        // only rt matches EX/MEM: port A stays on the regfile
        bus.exm_reg_write = 1; bus.exm_rd = 5'd9; bus.exm_result = 32'd70;
        bus.mwb_reg_write = 0;
        drive_id(32'd31, 32'd32, 6'd28, 5'd8, 5'd9, 5'd1, 1'b1);
        tick();
        e2 = FWD ? 32'd70 : 32'd32; ef = FWD ? 2'd1 : 2'd0;
        total++; if (bus.alu_src1 !== 32'd31 || bus.fwd_a !== 2'd0)
            $display("FAIL fwd_split_a got %0d sel %0d exp 31 sel 0", bus.alu_src1, bus.fwd_a); else passed++;
        total++; if (bus.alu_src2 !== e2 || bus.fwd_b !== ef)
            $display("FAIL fwd_split_b got %0d sel %0d exp %0d sel %0d", bus.alu_src2, bus.fwd_b, e2, ef); else passed++;
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        drive_id(32'd0, 32'd7, 6'd30, 5'd0, 5'd3, 5'd2, 1'b1);
        bus.exm_reg_write = 1; bus.exm_rd = 5'd0; bus.exm_result = 32'd123;
        bus.mwb_reg_write = 1; bus.mwb_rd = 5'd0; bus.mwb_result = 32'd124;
        tick();
        total++; if (bus.alu_src1 !== 32'd0 || bus.fwd_a !== 2'd0)
            $display("FAIL zero_fwd got %0d sel %0d exp 0 sel 0", bus.alu_src1, bus.fwd_a); else passed++;
        drive_id(32'd8, 32'd9, 6'd27, 5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        total++; if (bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b1)
            $display("FAIL zero_rd got wr %0b v %0b exp wr 0 v 1", bus.ex_reg_write, bus.ex_valid); else passed++;
    endtask

    task automatic test_stall_flush();
        logic [DATA_W-1:0] e1;
        clear_inputs();
        drive_id(32'd123, 32'd456, 6'd29, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_id(32'(1000 + i), 32'(2000 + i), 6'd30, 5'd7, 5'd8, 5'd9, 1'b0);
            tick();
            total++; if (bus.alu_src1 !== 32'd123 || bus.alu_src2 !== 32'd456 || bus.alu_operation !== 6'd29)
                $display("FAIL stall_hold%0d got %0d/%0d op %0d exp 123/456 op 29", i,
                         bus.alu_src1, bus.alu_src2, bus.alu_operation); else passed++;
        end
        // forwarding stays live while stalled
        bus.exm_reg_write = 1; bus.exm_rd = 5'd1; bus.exm_result = 32'd777;
        #1;
        e1 = FWD ? 32'd777 : 32'd123;
        total++; if (bus.alu_src1 !== e1) $display("FAIL stall_fwd got %0d exp %0d", bus.alu_src1, e1); else passed++;
        bus.exm_reg_write = 0;
        flush = 1;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.alu_operation !== 6'd0 || bus.ex_reg_write !== 1'b0)
            $display("FAIL flush_bubble got v%0b op %0d w%0b exp v0 op 0 w0", bus.ex_valid,
                     bus.alu_operation, bus.ex_reg_write); else passed++;
        total++; if (bus.alu_src1 !== '0 || bus.alu_src2 !== '0 || bus.ex_rd !== '0)
            $display("FAIL flush_data got %0d/%0d rd %0d exp 0/0 rd 0", bus.alu_src1, bus.alu_src2, bus.ex_rd); else passed++;
        // id_valid=0 behaves as a bubble
        flush = 0; stall = 0;
        drive_id(32'd5, 32'd6, 6'd27, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        bus.id_valid = 0;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.alu_operation !== 6'd0 || bus.alu_src1 !== '0)
            $display("FAIL invalid_bubble got v%0b op %0d src1 %0d exp v0 op 0 src1 0", bus.ex_valid,
                     bus.alu_operation, bus.alu_src1); else passed++;
    endtask

    task automatic test_imm_illegal();
        logic [1:0] ef;
        clear_inputs();
        drive_id(32'd40, 32'd55, 6'd31, 5'd2, 5'd6, 5'd7, 1'b1);
        bus.id_use_imm = 1; bus.id_imm = 32'd10; bus.id_shamt = 5'd3;
        bus.exm_reg_write = 1; bus.exm_rd = 5'd6; bus.exm_result = 32'd66;
        tick();
        ef = FWD ? 2'd1 : 2'd0;
        total++; if (bus.alu_src2 !== 32'd10 || bus.alu_shamt !== 5'd3 || bus.alu_operation !== 6'd31)
            $display("FAIL imm_shift got %0d sh %0d op %0d exp 10 sh 3 op 31", bus.alu_src2,
                     bus.alu_shamt, bus.alu_operation); else passed++;
        total++; if (bus.fwd_b !== ef) $display("FAIL imm_fwd_b got %0d exp %0d", bus.fwd_b, ef); else passed++;
        bus.exm_reg_write = 0; bus.id_use_imm = 0;
        drive_id(32'd1, 32'd2, 6'd45, 5'd1, 5'd2, 5'd7, 1'b1);
        tick();
        total++; if (bus.alu_operation !== 6'd0 || bus.ex_illegal_op !== 1'b1 || bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b1)
            $display("FAIL illegal45 got op %0d ill %0b w %0b v %0b exp op 0 ill 1 w 0 v 1",
                     bus.alu_operation, bus.ex_illegal_op, bus.ex_reg_write, bus.ex_valid); else passed++;
        drive_id(32'd1, 32'd2, 6'd32, 5'd1, 5'd2, 5'd7, 1'b1);
        tick();
        total++; if (bus.alu_operation !== 6'd32 || bus.ex_illegal_op !== 1'b0 || bus.ex_reg_write !== 1'b1)
            $display("FAIL legal32 got op %0d ill %0b w %0b exp op 32 ill 0 w 1",
                     bus.alu_operation, bus.ex_illegal_op, bus.ex_reg_write); else passed++;
        drive_id(32'd1, 32'd2, 6'd26, 5'd1, 5'd2, 5'd7, 1'b1);
        tick();
        total++; if (bus.alu_operation !== 6'd0 || bus.ex_illegal_op !== 1'b1)
            $display("FAIL illegal26 got op %0d ill %0b exp op 0 ill 1", bus.alu_operation, bus.ex_illegal_op); else passed++;
        drive_id(32'd1, 32'd2, 6'd0, 5'd1, 5'd2, 5'd7, 1'b0);
        tick();
        total++; if (bus.ex_illegal_op !== 1'b0 || bus.ex_valid !== 1'b1)
            $display("FAIL nop_legal got ill %0b v %0b exp ill 0 v 1", bus.ex_illegal_op, bus.ex_valid); else passed++;
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_forward_priority();
        test_zero_reg();
        test_stall_flush();
        test_imm_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
